// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - C = A x B control sequencer over one operand RAM and one dot-product unit (optional perf counters: MATMUL_SEQ_PERF_EN)
module matmul_sequencer #(
    parameter int AROW       = 2,
    parameter int ACOL       = 2,
    parameter int BCOL       = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int IDX_WIDTH  = (ACOL > 1) ? $clog2(ACOL) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [ADDR_WIDTH-1:0] c_base,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  load_a,
    output logic                  load_b,
    output logic [IDX_WIDTH-1:0]  load_idx,
    output logic                  dp_start,
    input  logic                  dp_done,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_ready
`ifdef MATMUL_SEQ_PERF_EN
    ,
    output logic [31:0]           cycle_count,
    output logic [31:0]           stall_count
`endif
);

    localparam int I_WIDTH = (AROW > 1) ? $clog2(AROW) : 1;
    localparam int J_WIDTH = (BCOL > 1) ? $clog2(BCOL) : 1;

    localparam logic [ADDR_WIDTH-1:0] ACOL_A = ADDR_WIDTH'(ACOL);
    localparam logic [ADDR_WIDTH-1:0] BCOL_A = ADDR_WIDTH'(BCOL);
    localparam logic [IDX_WIDTH-1:0]  K_LAST = IDX_WIDTH'(ACOL - 1);
    localparam logic [I_WIDTH-1:0]    I_LAST = I_WIDTH'(AROW - 1);
    localparam logic [J_WIDTH-1:0]    J_LAST = J_WIDTH'(BCOL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_RD_WAIT,
        S_COMPUTE,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic [I_WIDTH-1:0]      i_q;
    logic [J_WIDTH-1:0]      j_q;
    logic [IDX_WIDTH-1:0]    k_q;
    logic [ADDR_WIDTH-1:0]   a_base_q;
    logic [ADDR_WIDTH-1:0]   b_base_q;
    logic [ADDR_WIDTH-1:0]   c_base_q;
    logic                    dp_first_q;
    logic                    load_a_q;
    logic                    load_b_q;
    logic [IDX_WIDTH-1:0]    load_idx_q;

    logic                    k_last;
    logic                    i_last;
    logic                    j_last;
    logic                    start_accept;
    logic                    wr_accept;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [ADDR_WIDTH-1:0]   b_addr;
    logic [ADDR_WIDTH-1:0]   c_addr;

    assign k_last       = (k_q == K_LAST);
    assign i_last       = (i_q == I_LAST);
    assign j_last       = (j_q == J_LAST);
    assign start_accept = (state == S_IDLE) && start;
    assign wr_accept    = (state == S_WRITE) && wr_ready;

    // Address sums are truncated to ADDR_WIDTH, so they wrap naturally.
    assign a_addr = a_base_q + ADDR_WIDTH'(i_q) * ACOL_A + ADDR_WIDTH'(k_q);
    assign b_addr = b_base_q + ADDR_WIDTH'(j_q) * ACOL_A + ADDR_WIDTH'(k_q);
    assign c_addr = c_base_q + ADDR_WIDTH'(i_q) * BCOL_A + ADDR_WIDTH'(j_q);

    assign load_a   = load_a_q;
    assign load_b   = load_b_q;
    assign load_idx = load_idx_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; every output is idle-low outside its own state.
    always_comb begin
        next_state = state;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        dp_start   = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                rd_en   = 1'b1;
                rd_addr = a_addr;
                if (k_last) begin
                    next_state = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                rd_en   = 1'b1;
                rd_addr = b_addr;
                if (k_last) begin
                    next_state = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                next_state = S_COMPUTE;
            end
            S_COMPUTE: begin
                dp_start = dp_first_q;
                if (dp_done) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = c_addr;
                if (wr_ready) begin
                    if (!j_last) begin
                        next_state = S_LOAD_B;
                    end else if (!i_last) begin
                        next_state = S_LOAD_A;
                    end else begin
                        next_state = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Base latching and the i/j/k loop counters; the A row is kept while j advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
        end else if (start_accept) begin
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_base_q <= a_base;
            b_base_q <= b_base;
            c_base_q <= c_base;
        end else if ((state == S_LOAD_A) || (state == S_LOAD_B)) begin
            k_q <= k_last ? '0 : k_q + IDX_WIDTH'(1);
        end else if (wr_accept) begin
            if (!j_last) begin
                j_q <= j_q + J_WIDTH'(1);
            end else if (!i_last) begin
                j_q <= '0;
                i_q <= i_q + I_WIDTH'(1);
            end
        end
    end

    // Load strobes trail the read by one cycle to line up with the RAM's returned data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_a_q   <= 1'b0;
            load_b_q   <= 1'b0;
            load_idx_q <= '0;
        end else begin
            load_a_q   <= (state == S_LOAD_A);
            load_b_q   <= (state == S_LOAD_B);
            load_idx_q <= k_q;
        end
    end

    // RD_WAIT is always exactly one cycle, so this marks the first COMPUTE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_first_q <= 1'b0;
        end else begin
            dp_first_q <= (state == S_RD_WAIT);
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    // Busy-cycle and stall-cycle counters, cleared when a new multiply is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            stall_count <= '0;
        end else if (start_accept) begin
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            if (state != S_IDLE) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (((state == S_COMPUTE) && !dp_done) || ((state == S_WRITE) && !wr_ready)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - randomized self-checking bench for matmul_sequencer
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s    [2];
    logic [15:0] a_b        [2];
    logic [15:0] b_b        [2];
    logic [15:0] c_b        [2];
    logic        busy_s     [2];
    logic        done_s     [2];
    logic        rd_en_s    [2];
    logic [15:0] rd_addr_s  [2];
    logic        load_a_s   [2];
    logic        load_b_s   [2];
    logic [0:0]  load_idx_s [2];
    logic        dp_start_s [2];
    logic        dp_done_s  [2];
    logic        wr_en_s    [2];
    logic [15:0] wr_addr_s  [2];
    logic        wr_ready_s [2];
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] cyc_cnt    [2];
    logic [31:0] stl_cnt    [2];
`endif

    int n_checks = 0;
    int n_errors = 0;

    // responder configuration (written by the main process only)
    int dp_delay   [2];
    int stall_wr   [2];
    int stall_len  [2];
    bit rand_ready [2];

    // monitor state (written by the negedge process only)
    logic [15:0] rd_log   [2][64];
    int          ld_log   [2][64];
    logic [15:0] wr_log   [2][16];
    int          hold_log [2][16];
    int rd_n[2], ld_n[2], wr_n[2], dp_n[2], done_n[2];
    int overlap[2], hold_err[2], hold_cnt[2], stall_cnt[2], dp_cnt[2];
    bit dp_pend[2], clr_done[2], prev_wait[2];
    logic [15:0] prev_waddr[2];

    always #5 clk = ~clk;

    matmul_sequencer #(.AROW(2), .ACOL(2), .BCOL(2), .ADDR_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]),
        .a_base(a_b[0]), .b_base(b_b[0]), .c_base(c_b[0]),
        .busy(busy_s[0]), .done(done_s[0]), .rd_en(rd_en_s[0]), .rd_addr(rd_addr_s[0]),
        .load_a(load_a_s[0]), .load_b(load_b_s[0]), .load_idx(load_idx_s[0]),
        .dp_start(dp_start_s[0]), .dp_done(dp_done_s[0]),
        .wr_en(wr_en_s[0]), .wr_addr(wr_addr_s[0]), .wr_ready(wr_ready_s[0])
`ifdef MATMUL_SEQ_PERF_EN
        , .cycle_count(cyc_cnt[0]), .stall_count(stl_cnt[0])
`endif
    );

    matmul_sequencer #(.AROW(1), .ACOL(1), .BCOL(3), .ADDR_WIDTH(16)) dut_edge (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]),
        .a_base(a_b[1]), .b_base(b_b[1]), .c_base(c_b[1]),
        .busy(busy_s[1]), .done(done_s[1]), .rd_en(rd_en_s[1]), .rd_addr(rd_addr_s[1]),
        .load_a(load_a_s[1]), .load_b(load_b_s[1]), .load_idx(load_idx_s[1]),
        .dp_start(dp_start_s[1]), .dp_done(dp_done_s[1]),
        .wr_en(wr_en_s[1]), .wr_addr(wr_addr_s[1]), .wr_ready(wr_ready_s[1])
`ifdef MATMUL_SEQ_PERF_EN
        , .cycle_count(cyc_cnt[1]), .stall_count(stl_cnt[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Dot-product/memory responder and transaction monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                dp_done_s[g]  = 1'b0;
                wr_ready_s[g] = 1'b0;
                dp_pend[g]    = 1'b0;
                clr_done[g]   = 1'b0;
                prev_wait[g]  = 1'b0;
                hold_cnt[g]   = 0;
            end else begin
                if (start_s[g] && !busy_s[g]) begin
                    rd_n[g] = 0; ld_n[g] = 0; wr_n[g] = 0; dp_n[g] = 0; done_n[g] = 0;
                    overlap[g] = 0; hold_err[g] = 0; hold_cnt[g] = 0; stall_cnt[g] = 0;
                end
                if (clr_done[g]) begin
                    dp_done_s[g] = 1'b0;
                    dp_pend[g]   = 1'b0;
                    clr_done[g]  = 1'b0;
                end
                if (dp_start_s[g]) begin
                    dp_n[g]++;
                    dp_pend[g] = 1'b1;
                    dp_cnt[g]  = (dp_delay[g] < 0) ? int'($urandom_range(0, 3)) : dp_delay[g];
                end
                if (dp_pend[g]) begin
                    if (dp_cnt[g] == 0) dp_done_s[g] = 1'b1;
                    else dp_cnt[g]--;
                end
                wr_ready_s[g] = 1'b0;
                if (wr_en_s[g]) begin
                    if (wr_n[g] == stall_wr[g] && stall_cnt[g] < stall_len[g]) stall_cnt[g]++;
                    else if (rand_ready[g]) wr_ready_s[g] = ($urandom_range(0, 2) != 0);
                    else wr_ready_s[g] = 1'b1;
                end
                if (prev_wait[g] && !(wr_en_s[g] && wr_addr_s[g] == prev_waddr[g])) hold_err[g]++;
                if (rd_en_s[g] && wr_en_s[g]) overlap[g]++;
                if (rd_en_s[g] && rd_n[g] < 64) begin
                    rd_log[g][rd_n[g]] = rd_addr_s[g];
                    rd_n[g]++;
                end
                if ((load_a_s[g] || load_b_s[g]) && ld_n[g] < 64) begin
                    ld_log[g][ld_n[g]] = (load_b_s[g] ? 2 : 0) + (load_a_s[g] && load_b_s[g] ? 4 : 0) + int'(load_idx_s[g]);
                    ld_n[g]++;
                end
                if (wr_en_s[g]) hold_cnt[g]++;
                prev_wait[g]  = wr_en_s[g] && !wr_ready_s[g];
                prev_waddr[g] = wr_addr_s[g];
                if (wr_en_s[g] && wr_ready_s[g] && wr_n[g] < 16) begin
                    wr_log[g][wr_n[g]]   = wr_addr_s[g];
                    hold_log[g][wr_n[g]] = hold_cnt[g];
                    wr_n[g]++;
                    hold_cnt[g] = 0;
                    clr_done[g] = 1'b1;
                end
                if (done_s[g]) done_n[g]++;
            end
        end
    end

    task automatic check_idle_outputs(input int g, input string tag);
        check({tag, "_ctl"}, 32'({busy_s[g], done_s[g], rd_en_s[g], wr_en_s[g], dp_start_s[g],
                                  load_a_s[g], load_b_s[g], load_idx_s[g]}), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr_s[g]), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr_s[g]), 32'd0);
    endtask

    // Launch one multiply; optionally poke start during LOAD_B or reset during C[1][0] compute.
    task automatic run(input int g, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input bit poke, input bit rst_mid);
        int  cyc;
        bit  poked;
        cyc   = 0;
        poked = 0;
        a_b[g] = a; b_b[g] = b; c_b[g] = c;
        @(posedge clk); #1 start_s[g] = 1'b1;
        @(posedge clk); #1 start_s[g] = 1'b0;
        while (done_n[g] == 0 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            start_s[g] = 1'b0;
            if (poke && !poked && rd_n[g] == 3) begin
                start_s[g] = 1'b1;
                a_b[g] = 16'($urandom); b_b[g] = 16'($urandom); c_b[g] = 16'($urandom);
                poked = 1;
            end
            if (rst_mid && dp_n[g] == 3) begin
                rst_n = 1'b0;
                #1;
                check_idle_outputs(g, "mid_reset");
                break;
            end
        end
        start_s[g] = 1'b0;
        if (!rst_mid) check("done_seen", 32'(done_n[g] > 0), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Reference: loop nest over i, j, k with wrapping 16-bit address arithmetic.
    task automatic compare(input int g, input int ar, input int ac, input int bc,
                           input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                           input string tag);
        int n, m;
        logic [15:0] e;
        n = 0;
        m = 0;
        check({tag, "_rd_count"}, 32'(rd_n[g]), 32'(ar * (ac + bc * ac)));
        check({tag, "_wr_count"}, 32'(wr_n[g]), 32'(ar * bc));
        for (int i = 0; i < ar; i++) begin
            for (int k = 0; k < ac; k++) begin
                e = a + 16'(i * ac + k);
                check({tag, "_rd_a"}, 32'(rd_log[g][n]), 32'(e));
                check({tag, "_ld_a"}, 32'(ld_log[g][n]), 32'(k));
                n++;
            end
            for (int j = 0; j < bc; j++) begin
                for (int k = 0; k < ac; k++) begin
                    e = b + 16'(j * ac + k);
                    check({tag, "_rd_b"}, 32'(rd_log[g][n]), 32'(e));
                    check({tag, "_ld_b"}, 32'(ld_log[g][n]), 32'(2 + k));
                    n++;
                end
                e = c + 16'(i * bc + j);
                check({tag, "_wr_addr"}, 32'(wr_log[g][m]), 32'(e));
                m++;
            end
        end
        check({tag, "_ld_count"}, 32'(ld_n[g]), 32'(n));
        check({tag, "_dp_starts"}, 32'(dp_n[g]), 32'(ar * bc));
        check({tag, "_done_pulses"}, 32'(done_n[g]), 32'd1);
        check({tag, "_rd_wr_overlap"}, 32'(overlap[g]), 32'd0);
        check({tag, "_wr_hold"}, 32'(hold_err[g]), 32'd0);
        check({tag, "_idle_after"}, 32'(busy_s[g]), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb, rc;
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            start_s[g] = 1'b0; a_b[g] = '0; b_b[g] = '0; c_b[g] = '0;
            dp_delay[g] = 2; stall_wr[g] = -1; stall_len[g] = 0; rand_ready[g] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs(0, "reset");
        check_idle_outputs(1, "reset_edge");
        rst_n = 1'b1;

        run(0, 16'h10, 16'h20, 16'h30, 0, 0);
        compare(0, 2, 2, 2, 16'h10, 16'h20, 16'h30, "nominal");

        stall_wr[0] = 1; stall_len[0] = 3;
        run(0, 16'h10, 16'h20, 16'h30, 0, 0);
        compare(0, 2, 2, 2, 16'h10, 16'h20, 16'h30, "backpressure");
        check("bp_hold_cycles", 32'(hold_log[0][1]), 32'd4);
        check("bp_first_hold", 32'(hold_log[0][0]), 32'd1);
`ifdef MATMUL_SEQ_PERF_EN
        check("bp_cycle_count", cyc_cnt[0], 32'(2 * 2 + 4 * (2 + 1 + 3 + 1) + 3 + 1));
        check("bp_stall_count", stl_cnt[0], 32'(4 * 2 + 3));
`endif
        stall_wr[0] = -1; stall_len[0] = 0;

        run(0, 16'h10, 16'h20, 16'h30, 1, 0);
        compare(0, 2, 2, 2, 16'h10, 16'h20, 16'h30, "start_busy");

        dp_delay[0] = 3;
        run(0, 16'h10, 16'h20, 16'h30, 0, 1);
        check("mid_reset_writes", 32'(wr_n[0]), 32'd2);
        check("mid_reset_done", 32'(done_n[0]), 32'd0);
        check_idle_outputs(0, "in_reset");
        rst_n = 1'b1;
        dp_delay[0] = 2;
        run(0, 16'h10, 16'h20, 16'h30, 0, 0);
        compare(0, 2, 2, 2, 16'h10, 16'h20, 16'h30, "after_reset");

        dp_delay[0] = -1; rand_ready[0] = 1'b1;
        for (int r = 0; r < 6; r++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom);
            if (r == 0) ra = 16'hFFFE;
            run(0, ra, rb, rc, 0, 0);
            compare(0, 2, 2, 2, ra, rb, rc, "random");
        end

        run(1, 16'h40, 16'h50, 16'h60, 0, 0);
        compare(1, 1, 1, 3, 16'h40, 16'h50, 16'h60, "edge");
        dp_delay[1] = -1; rand_ready[1] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 16'hFFFF;
            run(1, ra, rb, rc, 0, 0);
            compare(1, 1, 1, 3, ra, rb, rc, "edge_random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
